// File: rtl/spi_obi_arbiter.sv
// Two-requester round-robin OBI arbiter sharing one OBI master port.
// Port 0 is the SPI slave plug, port 1 is a second on-chip requester.
// A stalled address phase locks the selection until it is granted, and an
// in-order ID FIFO routes each response back to the requester that issued it.
module spi_obi_arbiter #(
    parameter int OBI_ADDR_WIDTH  = 32,
    parameter int OBI_DATA_WIDTH  = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                      obi_aclk,
    input  logic                      obi_aresetn,

    input  logic                      s0_req,
    output logic                      s0_gnt,
    input  logic [OBI_ADDR_WIDTH-1:0] s0_addr,
    input  logic                      s0_we,
    input  logic [OBI_DATA_WIDTH-1:0] s0_w_data,
    input  logic [3:0]                s0_be,
    output logic                      s0_r_valid,
    output logic [OBI_DATA_WIDTH-1:0] s0_r_data,

    input  logic                      s1_req,
    output logic                      s1_gnt,
    input  logic [OBI_ADDR_WIDTH-1:0] s1_addr,
    input  logic                      s1_we,
    input  logic [OBI_DATA_WIDTH-1:0] s1_w_data,
    input  logic [3:0]                s1_be,
    output logic                      s1_r_valid,
    output logic [OBI_DATA_WIDTH-1:0] s1_r_data,

    output logic                      obi_master_req,
    input  logic                      obi_master_gnt,
    output logic [OBI_ADDR_WIDTH-1:0] obi_master_addr,
    output logic                      obi_master_we,
    output logic [OBI_DATA_WIDTH-1:0] obi_master_w_data,
    output logic [3:0]                obi_master_be,
    input  logic                      obi_master_r_valid,
    input  logic [OBI_DATA_WIDTH-1:0] obi_master_r_data,

    output logic                      busy,
    output logic                      err_spurious_rvalid
);

    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic             rr_ptr_q, rr_ptr_d;
    logic             lock_q, lock_d;
    logic             lock_id_q, lock_id_d;
    logic             err_q, err_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             fifo_q [MAX_OUTSTANDING];
    logic             fifo_d [MAX_OUTSTANDING];

    logic sel_valid;
    logic sel;
    logic full;
    logic push;
    logic pop;
    logic head;

    // Pointer advance with wrap at the FIFO depth (depth need not be a power of two).
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(MAX_OUTSTANDING - 1)) return '0;
        else                                  return p + PTR_W'(1);
    endfunction

    // Selection, address-phase mux, grant and response routing.
    always_comb begin
        sel_valid = 1'b0;
        sel       = 1'b0;
        if (lock_q) begin
            sel_valid = 1'b1;
            sel       = lock_id_q;
        end else begin
            case ({s1_req, s0_req})
                2'b01:   begin sel_valid = 1'b1; sel = 1'b0;     end
                2'b10:   begin sel_valid = 1'b1; sel = 1'b1;     end
                2'b11:   begin sel_valid = 1'b1; sel = rr_ptr_q; end
                default: begin sel_valid = 1'b0; sel = 1'b0;     end
            endcase
        end

        // Only the registered count decides fullness: a pop this cycle does not free a slot.
        full = (count_q == CNT_W'(MAX_OUTSTANDING));

        obi_master_req = obi_aresetn && sel_valid && !full;
        push           = obi_master_req && obi_master_gnt;
        s0_gnt         = push && (sel == 1'b0);
        s1_gnt         = push && (sel == 1'b1);

        obi_master_addr   = (sel_valid && sel) ? s1_addr   : s0_addr;
        obi_master_we     = (sel_valid && sel) ? s1_we     : s0_we;
        obi_master_w_data = (sel_valid && sel) ? s1_w_data : s0_w_data;
        obi_master_be     = (sel_valid && sel) ? s1_be     : s0_be;

        head       = fifo_q[rd_ptr_q];
        pop        = obi_aresetn && obi_master_r_valid && (count_q != '0);
        s0_r_valid = pop && (head == 1'b0);
        s1_r_valid = pop && (head == 1'b1);
        s0_r_data  = obi_master_r_data;
        s1_r_data  = obi_master_r_data;

        busy                = (count_q != '0) || lock_q;
        err_spurious_rvalid = err_q;
    end

    // Next-state for round-robin pointer, stall lock, ID FIFO and error flag.
    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        err_d     = err_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        fifo_d    = fifo_q;

        if (push) begin
            rr_ptr_d         = ~sel;
            lock_d           = 1'b0;
            fifo_d[wr_ptr_q] = sel;
            wr_ptr_d         = ptr_inc(wr_ptr_q);
        end else if (obi_master_req) begin
            // Address phase must stay stable until granted.
            lock_d    = 1'b1;
            lock_id_d = sel;
        end

        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end

        if (obi_master_r_valid && (count_q == '0)) begin
            err_d = 1'b1;
        end
    end

    // Control state register with synchronous active-low reset.
    always_ff @(posedge obi_aclk) begin
        if (!obi_aresetn) begin
            rr_ptr_q  <= 1'b0;
            lock_q    <= 1'b0;
            lock_id_q <= 1'b0;
            err_q     <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
            err_q     <= err_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    // ID storage; entries are only meaningful below count, so no reset is needed.
    always_ff @(posedge obi_aclk) begin
        fifo_q <= fifo_d;
    end

endmodule

// File: tb/tb_spi_obi_arbiter.sv
// Directed bench for spi_obi_arbiter: a vector table for round-robin and
// single-requester traffic, plus hand sequences for stall lock, full FIFO,
// response ordering, spurious responses and mid-transaction reset.
module tb_spi_obi_arbiter;

    logic        clk;
    logic        rst_n;
    logic        s0_req, s1_req, s0_gnt, s1_gnt;
    logic [31:0] s0_addr, s1_addr, s0_w_data, s1_w_data;
    logic        s0_we, s1_we;
    logic [3:0]  s0_be, s1_be;
    logic        s0_r_valid, s1_r_valid;
    logic [31:0] s0_r_data, s1_r_data;
    logic        m_req, m_gnt, m_we, m_r_valid;
    logic [31:0] m_addr, m_w_data, m_r_data;
    logic [3:0]  m_be;
    logic        busy, err;

    int n_tests = 0;
    int n_fail  = 0;

    spi_obi_arbiter #(
        .OBI_ADDR_WIDTH (32),
        .OBI_DATA_WIDTH (32),
        .MAX_OUTSTANDING(2)
    ) dut (
        .obi_aclk           (clk),
        .obi_aresetn        (rst_n),
        .s0_req             (s0_req),
        .s0_gnt             (s0_gnt),
        .s0_addr            (s0_addr),
        .s0_we              (s0_we),
        .s0_w_data          (s0_w_data),
        .s0_be              (s0_be),
        .s0_r_valid         (s0_r_valid),
        .s0_r_data          (s0_r_data),
        .s1_req             (s1_req),
        .s1_gnt             (s1_gnt),
        .s1_addr            (s1_addr),
        .s1_we              (s1_we),
        .s1_w_data          (s1_w_data),
        .s1_be              (s1_be),
        .s1_r_valid         (s1_r_valid),
        .s1_r_data          (s1_r_data),
        .obi_master_req     (m_req),
        .obi_master_gnt     (m_gnt),
        .obi_master_addr    (m_addr),
        .obi_master_we      (m_we),
        .obi_master_w_data  (m_w_data),
        .obi_master_be      (m_be),
        .obi_master_r_valid (m_r_valid),
        .obi_master_r_data  (m_r_data),
        .busy               (busy),
        .err_spurious_rvalid(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        s0_req;
        logic        s1_req;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        e_req;
        logic        e_g0;
        logic        e_g1;
        logic        e_rv0;
        logic        e_rv1;
        logic        e_busy;
        logic [31:0] e_addr;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge; outputs are sampled 3 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r0, input logic r1, input logic g,
                         input logic rv, input logic [31:0] rd);
        s0_req    = r0;
        s1_req    = r1;
        m_gnt     = g;
        m_r_valid = rv;
        m_r_data  = rd;
        #2;
    endtask

    function automatic vec_t mk(input logic r0, input logic r1, input logic g, input logic rv,
                                input logic [31:0] rd, input logic eq, input logic eg0,
                                input logic eg1, input logic erv0, input logic erv1,
                                input logic eb, input logic [31:0] ea);
        vec_t v;
        v.s0_req = r0; v.s1_req = r1; v.gnt = g; v.rv = rv; v.rdata = rd;
        v.e_req = eq; v.e_g0 = eg0; v.e_g1 = eg1; v.e_rv0 = erv0; v.e_rv1 = erv1;
        v.e_busy = eb; v.e_addr = ea;
        return v;
    endfunction

    initial begin
        // Contention: both request, gnt always high, response one cycle after each grant.
        vecs[0] = mk(1, 1, 1, 0, 32'h0,  1, 1, 0, 0, 0, 0, 32'h1000);
        vecs[1] = mk(1, 1, 1, 1, 32'hA1, 1, 0, 1, 1, 0, 1, 32'h2000);
        vecs[2] = mk(1, 1, 1, 1, 32'hA2, 1, 1, 0, 0, 1, 1, 32'h1000);
        vecs[3] = mk(1, 1, 1, 1, 32'hA3, 1, 0, 1, 1, 0, 1, 32'h2000);
        vecs[4] = mk(0, 0, 1, 1, 32'hA4, 0, 0, 0, 0, 1, 1, 32'h1000);
        vecs[5] = mk(0, 0, 0, 0, 32'h0,  0, 0, 0, 0, 0, 0, 32'h1000);
        // Single requester: s0 write, response two cycles after grant.
        vecs[6] = mk(1, 0, 1, 0, 32'h0,  1, 1, 0, 0, 0, 0, 32'h1000);
        vecs[7] = mk(0, 0, 0, 0, 32'h0,  0, 0, 0, 0, 0, 1, 32'h1000);
        vecs[8] = mk(0, 0, 0, 1, 32'h5A, 0, 0, 0, 1, 0, 1, 32'h1000);
        vecs[9] = mk(0, 0, 0, 0, 32'h0,  0, 0, 0, 0, 0, 0, 32'h1000);

        s0_addr = 32'h1000; s0_we = 1'b1; s0_w_data = 32'hDEADBEEF; s0_be = 4'hF;
        s1_addr = 32'h2000; s1_we = 1'b0; s1_w_data = 32'h0;        s1_be = 4'h3;
        s0_req = 0; s1_req = 0; m_gnt = 0; m_r_valid = 0; m_r_data = 0;

        // Reset: outputs forced low while asserted, state clear after the edge.
        rst_n = 1'b0;
        drive(1, 1, 1, 1, 32'h0);
        chk("rst_req_forced", {31'b0, m_req}, 0);
        chk("rst_gnt_forced", {30'b0, s1_gnt, s0_gnt}, 0);
        chk("rst_rv_forced", {30'b0, s1_r_valid, s0_r_valid}, 0);
        tick();
        tick();
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 32'h0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_err", {31'b0, err}, 0);
        chk("rst_idle_req", {31'b0, m_req}, 0);

        // Table-driven contention and single-requester traffic.
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].s0_req, vecs[i].s1_req, vecs[i].gnt, vecs[i].rv, vecs[i].rdata);
            chk($sformatf("v%0d_req", i),  {31'b0, m_req},      {31'b0, vecs[i].e_req});
            chk($sformatf("v%0d_g0", i),   {31'b0, s0_gnt},     {31'b0, vecs[i].e_g0});
            chk($sformatf("v%0d_g1", i),   {31'b0, s1_gnt},     {31'b0, vecs[i].e_g1});
            chk($sformatf("v%0d_rv0", i),  {31'b0, s0_r_valid}, {31'b0, vecs[i].e_rv0});
            chk($sformatf("v%0d_rv1", i),  {31'b0, s1_r_valid}, {31'b0, vecs[i].e_rv1});
            chk($sformatf("v%0d_busy", i), {31'b0, busy},       {31'b0, vecs[i].e_busy});
            if (vecs[i].e_req) chk($sformatf("v%0d_addr", i), m_addr, vecs[i].e_addr);
            if (vecs[i].e_rv0) chk($sformatf("v%0d_rdata0", i), s0_r_data, vecs[i].rdata);
            if (vecs[i].e_rv1) chk($sformatf("v%0d_rdata1", i), s1_r_data, vecs[i].rdata);
            if (i == 6) begin
                chk("wr_we", {31'b0, m_we}, 1);
                chk("wr_data", m_w_data, 32'hDEADBEEF);
                chk("wr_be", {28'b0, m_be}, 32'hF);
            end
            tick();
        end

        // Stall lock: s1 alone with gnt low; s0 joins in cycle 1 but s1 keeps the port.
        drive(0, 1, 0, 0, 32'h0);
        chk("stall0_req", {31'b0, m_req}, 1);
        chk("stall0_addr", m_addr, 32'h2000);
        chk("stall0_g1", {31'b0, s1_gnt}, 0);
        tick();
        for (int c = 1; c < 3; c++) begin
            drive(1, 1, 0, 0, 32'h0);
            chk($sformatf("stall%0d_addr", c), m_addr, 32'h2000);
            chk($sformatf("stall%0d_g0", c), {31'b0, s0_gnt}, 0);
            chk($sformatf("stall%0d_busy", c), {31'b0, busy}, 1);
            tick();
        end
        drive(1, 1, 1, 0, 32'h0);
        chk("stall3_addr", m_addr, 32'h2000);
        chk("stall3_g1", {31'b0, s1_gnt}, 1);
        chk("stall3_g0", {31'b0, s0_gnt}, 0);
        tick();
        drive(1, 0, 1, 0, 32'h0);
        chk("after_stall_g0", {31'b0, s0_gnt}, 1);
        chk("after_stall_addr", m_addr, 32'h1000);
        tick();
        drive(0, 0, 0, 1, 32'h0);
        chk("stall_resp1", {30'b0, s1_r_valid, s0_r_valid}, 32'h2);
        tick();
        drive(0, 0, 0, 1, 32'h0);
        chk("stall_resp0", {30'b0, s1_r_valid, s0_r_valid}, 32'h1);
        tick();

        // Full FIFO and in-order response routing: s0 read, s1 read outstanding.
        s0_we = 1'b0;
        drive(1, 0, 1, 0, 32'h0);
        chk("fill_g0", {31'b0, s0_gnt}, 1);
        tick();
        drive(0, 1, 1, 0, 32'h0);
        chk("fill_g1", {31'b0, s1_gnt}, 1);
        tick();
        drive(1, 0, 1, 0, 32'h0);
        chk("full_req_low", {31'b0, m_req}, 0);
        chk("full_no_g0", {31'b0, s0_gnt}, 0);
        tick();
        drive(1, 0, 1, 1, 32'h11);
        chk("full_pop_req_low", {31'b0, m_req}, 0);
        chk("ord_rv_11", {30'b0, s1_r_valid, s0_r_valid}, 32'h1);
        chk("ord_data_11", s0_r_data, 32'h11);
        tick();
        drive(1, 0, 1, 1, 32'h22);
        chk("reassert_req", {31'b0, m_req}, 1);
        chk("pushpop_g0", {31'b0, s0_gnt}, 1);
        chk("ord_rv_22", {30'b0, s1_r_valid, s0_r_valid}, 32'h2);
        chk("ord_data_22", s1_r_data, 32'h22);
        tick();
        drive(0, 1, 1, 0, 32'h0);
        chk("refill_g1", {31'b0, s1_gnt}, 1);
        tick();
        drive(1, 0, 1, 0, 32'h0);
        chk("pushpop_count_full", {31'b0, m_req}, 0);
        tick();
        drive(0, 0, 0, 1, 32'h33);
        chk("ord_rv_33", {30'b0, s1_r_valid, s0_r_valid}, 32'h1);
        chk("ord_data_33", s0_r_data, 32'h33);
        tick();
        drive(0, 0, 0, 1, 32'h44);
        chk("ord_rv_44", {30'b0, s1_r_valid, s0_r_valid}, 32'h2);
        tick();
        drive(0, 0, 0, 0, 32'h0);
        chk("drained_busy", {31'b0, busy}, 0);
        chk("no_err_yet", {31'b0, err}, 0);

        // Spurious response with nothing outstanding.
        drive(0, 0, 0, 1, 32'h99);
        chk("spur_rv", {30'b0, s1_r_valid, s0_r_valid}, 0);
        tick();
        for (int c = 0; c < 3; c++) begin
            drive(0, 0, 0, 0, 32'h0);
            chk($sformatf("spur_err_sticky%0d", c), {31'b0, err}, 1);
            tick();
        end

        // Reset with one transaction outstanding.
        drive(1, 0, 1, 0, 32'h0);
        chk("pre_rst_g0", {31'b0, s0_gnt}, 1);
        tick();
        rst_n = 1'b0;
        drive(1, 0, 1, 1, 32'h0);
        chk("mid_rst_busy_before", {31'b0, busy}, 1);
        chk("mid_rst_req", {31'b0, m_req}, 0);
        chk("mid_rst_rv", {30'b0, s1_r_valid, s0_r_valid}, 0);
        tick();
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 32'h0);
        chk("post_rst_busy", {31'b0, busy}, 0);
        chk("post_rst_err", {31'b0, err}, 0);
        drive(0, 0, 0, 1, 32'h0);
        chk("post_rst_late_rv", {30'b0, s1_r_valid, s0_r_valid}, 0);
        tick();
        drive(0, 0, 0, 0, 32'h0);
        chk("post_rst_spur_err", {31'b0, err}, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_obi_arbiter.md
# spi_obi_arbiter

Two-requester OBI arbiter that shares a single OBI master port between the SPI slave OBI plug (port 0) and a second on-chip requester (port 1, e.g. a debug/config engine). It performs round-robin arbitration, holds a pending address phase stable until it is granted, and tracks outstanding transactions in an in-order ID FIFO so each read/write response reaches the requester that issued it. It sits between the SPI plug's OBI master and the system interconnect.

## Interface
- OBI_ADDR_WIDTH, 32, address width on all ports
- OBI_DATA_WIDTH, 32, data width on all ports
- MAX_OUTSTANDING, 2, depth of the response-ID FIFO (1..8)

- obi_aclk  in  1  clock
- obi_aresetn  in  1  reset; one clock; reset is synchronous and active-low
- s0_req / s1_req  in  1  requester address-phase request
- s0_gnt / s1_gnt  out  1  requester grant
- s0_addr / s1_addr  in  OBI_ADDR_WIDTH  address
- s0_we / s1_we  in  1  write enable
- s0_w_data / s1_w_data  in  OBI_DATA_WIDTH  write data
- s0_be / s1_be  in  4  byte enables
- s0_r_valid / s1_r_valid  out  1  response valid, routed
- s0_r_data / s1_r_data  out  OBI_DATA_WIDTH  response data (both driven from obi_master_r_data)
- obi_master_req  out  1  downstream request
- obi_master_gnt  in  1  downstream grant
- obi_master_addr / obi_master_we / obi_master_w_data / obi_master_be  out  as above  muxed address phase
- obi_master_r_valid  in  1  downstream response valid
- obi_master_r_data  in  OBI_DATA_WIDTH  downstream response data
- busy  out  1  outstanding count != 0 or lock held
- err_spurious_rvalid  out  1  sticky: r_valid seen with FIFO empty

## Operation
- State: rr_ptr (1 b, preferred port), lock (1 b), lock_id (1 b), ID FIFO (MAX_OUTSTANDING x 1 b, rd/wr pointers, count of $clog2(MAX_OUTSTANDING+1) bits), err flag.
- Selection: if lock, sel = lock_id. Else if exactly one sX_req high, sel = that port; if both, sel = rr_ptr; if none, no selection.
- full = (count == MAX_OUTSTANDING), from registered count only (a same-cycle pop does not free a slot).
- obi_master_req = selection valid && !full. Address-phase outputs muxed from sel; when no selection they output port 0 values (don't-care).
- sX_gnt = obi_master_req && obi_master_gnt && sel == X. Other port's gnt 0.
- Handshake (obi_master_req && obi_master_gnt): push sel into FIFO; rr_ptr <= ~sel; lock <= 0.
- Stall (obi_master_req && !obi_master_gnt): lock <= 1, lock_id <= sel. While locked, the other port is never selected, even if the locked port drops req (protocol violation; arbiter still holds sel and drives its current inputs).
- Response: obi_master_r_valid with count != 0 pops FIFO head h; sh_r_valid = 1, other r_valid = 0. With count == 0: no routing, both r_valid 0, err_spurious_rvalid <= 1 (cleared only by reset).
- Push and pop in same cycle: count unchanged, both pointers advance.
- busy = (count != 0) || lock.

## Timing
- Arbitration is combinational: sX_req -> obi_master_req and obi_master_gnt -> sX_gnt in the same cycle (zero latency).
- Response routing combinational: obi_master_r_valid -> sX_r_valid same cycle; r_data pass-through.
- rr_ptr, lock, FIFO, count, err update on posedge obi_aclk.
- Reset (obi_aresetn low at posedge): rr_ptr=0, lock=0, count=0, FIFO pointers=0, err=0. While obi_aresetn is low all of obi_master_req, s0_gnt, s1_gnt, s0_r_valid, s1_r_valid are forced 0; busy=0, err_spurious_rvalid=0 after the first reset edge.
- Reset mid-transaction discards outstanding IDs; responses arriving after reset count as spurious.
- Back-to-back: one handshake per cycle max; with MAX_OUTSTANDING=2 and zero-latency responses, sustained throughput is one transaction per cycle.

## Test plan
- Single requester: s0 write addr 0x1000, data 0xDEADBEEF, gnt same cycle, r_valid 2 cycles later -> obi_master_addr=0x1000, s0_gnt=1 same cycle, s0_r_valid=1, s1_r_valid=0, busy high exactly until the response.
- Contention fairness: s0 and s1 both request continuously, gnt always 1, r_valid 1 cycle later -> grants alternate s0,s1,s0,s1; each response routed to its issuer.
- Stall lock: s1 requests alone, gnt low 3 cycles; s0 raises req in cycle 1 -> obi_master_addr stays s1's for all 4 cycles; s1_gnt in cycle 4; s0 granted next cycle.
- Full: MAX_OUTSTANDING=2, two reads granted, no r_valid -> obi_master_req=0 with s0_req high; first r_valid -> req reasserts next cycle, not same cycle.
- Out-of-order IDs: s0 read, s1 read, s0 read outstanding; r_data 0x11,0x22,0x33 -> delivered to s0,s1,s0 in order; simultaneous push+pop keeps count at 2.
- Spurious/reset: r_valid with count 0 -> no sX_r_valid, err_spurious_rvalid=1 and stays 1; assert obi_aresetn=0 one cycle with 1 outstanding -> count 0, err 0, busy 0.
